// File: rtl/random_pulse_sched.sv
// rtl/random_pulse_sched.sv - draws LFSR words and emits pulses after random gaps
// Run modes: continuous (burst_len=0) or fixed burst, with start/stop control.
module random_pulse_sched #(
    parameter int GW = 16,
    parameter int PW = 8,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [31:0]   rnd,
    output logic          prng_ce,
    input  logic [GW-1:0] min_gap,
    input  logic [GW-1:0] gap_mask,
    input  logic [PW-1:0] pulse_width,
    input  logic [BW-1:0] burst_len,
    output logic          pulse,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_GAP, S_PULSE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [GW-1:0] r_min_gap;
    logic [GW-1:0] r_gap_mask;
    logic [PW-1:0] r_pw;
    logic [BW-1:0] r_burst_len;
    logic [GW-1:0] r_gap_cnt;
    logic [PW-1:0] r_pw_cnt;
    logic [BW-1:0] r_burst_cnt;
    logic          r_pulse;
    logic          r_done;

    logic [GW:0]   w_sum;
    logic [GW-1:0] w_gap;
    logic [PW-1:0] w_pw_eff;
    logic          w_pw_last;
    logic [BW-1:0] w_burst_next;
    logic          w_burst_end;
    logic          w_done_next;
    logic          w_unused;

    assign w_unused = ^rnd[31:GW];

    always_comb begin
        w_sum        = {1'b0, r_min_gap} + {1'b0, rnd[GW-1:0] & r_gap_mask};
        w_gap        = w_sum[GW] ? {GW{1'b1}} : w_sum[GW-1:0];
        w_pw_eff     = (r_pw == '0) ? PW'(1) : r_pw;
        w_pw_last    = (r_pw_cnt == w_pw_eff - PW'(1));
        w_burst_next = r_burst_cnt + BW'(1);
        w_burst_end  = (r_burst_len != '0) && (w_burst_next == r_burst_len);
    end

    always_comb begin
        w_next      = r_state;
        w_done_next = 1'b0;
        case (r_state)
            S_IDLE:  if (start && !stop) w_next = S_DRAW;
            S_DRAW:  w_next = (w_gap == '0) ? S_PULSE : S_GAP;
            // Counter holding 1 reaches 0 on this edge, so GAP lasts exactly gap cycles
            S_GAP:   if (r_gap_cnt == GW'(1)) w_next = S_PULSE;
            S_PULSE: begin
                if (w_pw_last) begin
                    if (w_burst_end) begin
                        w_next      = S_IDLE;
                        w_done_next = 1'b1;
                    end else begin
                        w_next = S_DRAW;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (stop && r_state != S_IDLE) begin
            w_next      = S_IDLE;
            w_done_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_min_gap   <= '0;
            r_gap_mask  <= '0;
            r_pw        <= '0;
            r_burst_len <= '0;
            r_gap_cnt   <= '0;
            r_pw_cnt    <= '0;
            r_burst_cnt <= '0;
            r_pulse     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pulse <= (w_next == S_PULSE);
            r_done  <= w_done_next;

            if (r_state == S_IDLE && start && !stop) begin
                r_min_gap   <= min_gap;
                r_gap_mask  <= gap_mask;
                r_pw        <= pulse_width;
                r_burst_len <= burst_len;
                r_burst_cnt <= '0;
            end

            if (r_state == S_DRAW)
                r_gap_cnt <= w_gap;
            else if (r_state == S_GAP)
                r_gap_cnt <= r_gap_cnt - GW'(1);

            if (r_state == S_PULSE) begin
                r_pw_cnt <= w_pw_last ? '0 : r_pw_cnt + PW'(1);
                if (w_pw_last) r_burst_cnt <= w_burst_next;
            end else begin
                r_pw_cnt <= '0;
            end
        end
    end

    assign prng_ce = (r_state == S_DRAW);
    assign busy    = (r_state != S_IDLE);
    assign pulse   = r_pulse;
    assign done    = r_done;

endmodule

// File: tb/tb_random_pulse_sched.sv
// tb/tb_random_pulse_sched.sv - directed self-checking bench for random_pulse_sched
module tb_random_pulse_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] rnd = 32'h0;
    logic        prng_ce;
    logic [15:0] min_gap = '0;
    logic [15:0] gap_mask = '0;
    logic [7:0]  pulse_width = '0;
    logic [7:0]  burst_len = '0;
    logic        pulse;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    int ce_cnt, p_cnt, rise_cnt, first_rise, last_rise, done_cnt, done_c, busy_fall;
    logic prev_pulse;

    random_pulse_sched #(.GW(16), .PW(8), .BW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .rnd(rnd),
        .prng_ce(prng_ce), .min_gap(min_gap), .gap_mask(gap_mask),
        .pulse_width(pulse_width), .burst_len(burst_len),
        .pulse(pulse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cfg(input logic [31:0] r, input logic [15:0] mg, input logic [15:0] gm,
                       input logic [7:0] pw, input logic [7:0] bl);
        rnd = r; min_gap = mg; gap_mask = gm; pulse_width = pw; burst_len = bl;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // c = number of edges after the start edge at each sample point
    task automatic capture(input int n);
        ce_cnt = 0; p_cnt = 0; rise_cnt = 0; first_rise = -1; last_rise = -1;
        done_cnt = 0; done_c = -1; busy_fall = -1; prev_pulse = 1'b0;
        for (int c = 0; c < n; c++) begin
            if (prng_ce) ce_cnt++;
            if (pulse) p_cnt++;
            if (pulse && !prev_pulse) begin
                rise_cnt++;
                if (first_rise < 0) first_rise = c;
                last_rise = c;
            end
            if (done) begin
                done_cnt++;
                if (done_c < 0) done_c = c;
            end
            if (!busy && busy_fall < 0) busy_fall = c;
            prev_pulse = pulse;
            @(posedge clk); #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (pulse !== 1'b0)   begin errors++; $display("FAIL reset_pulse actual=%b expected=0", pulse); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done actual=%b expected=0", done); end
        checks++; if (prng_ce !== 1'b0) begin errors++; $display("FAIL reset_ce actual=%b expected=0", prng_ce); end
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_start actual=%b expected=0", busy); end
    endtask

    task automatic test_single();
        cfg(32'h00000005, 16'd3, 16'h000F, 8'd2, 8'd1);
        do_start();
        capture(20);
        chk("single_ce_cnt", ce_cnt, 1);
        chk("single_first_rise", first_rise, 9);
        chk("single_pulse_cycles", p_cnt, 2);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_done_at", done_c, 11);
        chk("single_busy_fall", busy_fall, 11);
    endtask

    task automatic test_burst();
        cfg(32'h00000005, 16'd3, 16'h000F, 8'd2, 8'd3);
        do_start();
        capture(45);
        chk("burst_ce_cnt", ce_cnt, 3);
        chk("burst_rises", rise_cnt, 3);
        chk("burst_first_rise", first_rise, 9);
        chk("burst_last_rise", last_rise, 31);
        chk("burst_pulse_cycles", p_cnt, 6);
        chk("burst_done_cnt", done_cnt, 1);
        chk("burst_done_at", done_c, 33);
    endtask

    task automatic test_zero_gap_width();
        cfg(32'hFFFFFFFF, 16'd0, 16'h0000, 8'd0, 8'd4);
        do_start();
        capture(15);
        chk("zero_ce_cnt", ce_cnt, 4);
        chk("zero_rises", rise_cnt, 4);
        chk("zero_pulse_cycles", p_cnt, 4);
        chk("zero_first_rise", first_rise, 1);
        chk("zero_last_rise", last_rise, 7);
        chk("zero_done_at", done_c, 8);
    endtask

    task automatic test_saturation();
        cfg(32'h0000FFFF, 16'hFFF0, 16'hFFFF, 8'd2, 8'd1);
        do_start();
        capture(65545);
        chk("sat_first_rise", first_rise, 65536);
        chk("sat_pulse_cycles", p_cnt, 2);
        chk("sat_done_at", done_c, 65538);
    endtask

    task automatic test_stop();
        int done_seen;
        cfg(32'h00000005, 16'd3, 16'h000F, 8'd10, 8'd0);
        do_start();
        repeat (12) begin @(posedge clk); #1; end
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL stop_pulse_before actual=%b expected=1", pulse); end
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL stop_pulse_after actual=%b expected=0", pulse); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL stop_busy actual=%b expected=0", busy); end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy || pulse) done_seen++;
            @(posedge clk); #1;
        end
        chk("stop_quiet_cycles", done_seen, 0);
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        capture(15);
        chk("start_stop_ce", ce_cnt, 0);
        chk("start_stop_pulse", p_cnt, 0);
        chk("start_stop_busy_fall", busy_fall, 0);
    endtask

    task automatic test_reset_midrun();
        cfg(32'h00000000, 16'd0, 16'h0000, 8'd10, 8'd0);
        do_start();
        @(posedge clk); #1;
        checks++; if (pulse !== 1'b1) begin errors++; $display("FAIL midrun_pulse_high actual=%b expected=1", pulse); end
        #2 rst = 1'b1;
        #1;
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL midrun_async_pulse actual=%b expected=0", pulse); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL midrun_async_busy actual=%b expected=0", busy); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_zero_gap_width();
        test_saturation();
        test_stop();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
